// File: rtl/alu_pkg.sv
// Shared ALU types, constants and flag derivation used by the ALU pipeline stages.
package alu_pkg;

  // Flag word, packed MSB first so it maps directly onto {N, Z, C, V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } banderas_t;

  // seleccion[3:2] value identifying the arithmetic operation class.
  localparam logic [1:0] CLASE_ARIT = 2'b00;

  // Bit positions of each flag inside a banderas_t word.
  localparam int BIT_N = 3;
  localparam int BIT_Z = 2;
  localparam int BIT_C = 1;
  localparam int BIT_V = 0;

  // Build the flag word from the result MSB, a zero indication and the raw
  // carry/overflow bits. Carry and overflow only mean something for the
  // arithmetic class, so they are masked for logic/shift operations.
  function automatic banderas_t derivar_banderas(
    input logic       msb,
    input logic       cero,
    input logic       carry,
    input logic       overflow,
    input logic [3:0] seleccion
  );
    banderas_t b;
    logic      arit;
    arit = (seleccion[3:2] == CLASE_ARIT);
    b.n  = msb;
    b.z  = cero;
    b.c  = carry & arit;
    b.v  = overflow & arit;
    return b;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module contador_saturado #(
  parameter int ANCHO_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 borrar,
  input  logic                 inc,
  output logic [ANCHO_CNT-1:0] cuenta
);

  localparam logic [ANCHO_CNT-1:0] MAXIMO = '1;

  logic [ANCHO_CNT-1:0] cuenta_reg;
  logic [ANCHO_CNT-1:0] cuenta_next;

  // Next count: clear first, otherwise step up unless already at the top.
  always_comb begin
    cuenta_next = cuenta_reg;
    if (borrar) begin
      cuenta_next = '0;
    end else if (inc && (cuenta_reg != MAXIMO)) begin
      cuenta_next = cuenta_reg + ANCHO_CNT'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_reg <= '0;
    end else begin
      cuenta_reg <= cuenta_next;
    end
  end

  assign cuenta = cuenta_reg;

endmodule

// File: rtl/registro_banderas.sv
// Registered ALU result and flag stage with a one-entry valid/ready output
// register, a sticky overflow flag and a saturating overflow event counter.
module registro_banderas
  import alu_pkg::*;
#(
  parameter int ANCHO     = 4,
  parameter int ANCHO_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANCHO-1:0]     resultado,
  input  logic                 carry,
  input  logic                 overflow,
  input  logic [3:0]           seleccion,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ANCHO-1:0]     out_resultado,
  output logic [3:0]           out_banderas,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 borrar,
  output logic                 v_pegajoso,
  output logic [ANCHO_CNT-1:0] cnt_overflow
);

  logic             aceptar;
  logic             entregar;
  logic             cero;
  logic             v_entrada;
  logic [ANCHO-1:0] algun_uno;

  logic [ANCHO-1:0] resultado_reg, resultado_next;
  banderas_t        banderas_reg, banderas_next;
  logic             valid_reg, valid_next;
  logic             pegajoso_reg, pegajoso_next;

  // The single output slot can take a new entry when empty or being drained.
  assign in_ready = !valid_reg || out_ready;
  assign aceptar  = in_valid && in_ready;
  assign entregar = valid_reg && out_ready;

  // Zero detect as an OR chain across the result bits.
  assign algun_uno[0] = resultado[0];
  generate
    for (genvar gi = 1; gi < ANCHO; gi++) begin : g_cero
      assign algun_uno[gi] = algun_uno[gi-1] | resultado[gi];
    end
  endgenerate
  assign cero = ~algun_uno[ANCHO-1];

  assign banderas_next = derivar_banderas(resultado[ANCHO-1], cero, carry,
                                          overflow, seleccion);
  assign v_entrada = banderas_next[BIT_V];

  // Output slot next state: load on accept, empty on give alone, else hold.
  always_comb begin
    resultado_next = resultado_reg;
    valid_next     = valid_reg;
    if (aceptar) begin
      resultado_next = resultado;
      valid_next     = 1'b1;
    end else if (entregar) begin
      valid_next     = 1'b0;
    end
  end

  // Sticky overflow: clear wins over a simultaneous overflow accept.
  always_comb begin
    pegajoso_next = pegajoso_reg;
    if (borrar) begin
      pegajoso_next = 1'b0;
    end else if (aceptar && v_entrada) begin
      pegajoso_next = 1'b1;
    end
  end

  // Output register; flags load only together with their result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultado_reg <= '0;
      banderas_reg  <= '0;
      valid_reg     <= 1'b0;
      pegajoso_reg  <= 1'b0;
    end else begin
      resultado_reg <= resultado_next;
      valid_reg     <= valid_next;
      pegajoso_reg  <= pegajoso_next;
      if (aceptar) begin
        banderas_reg <= banderas_next;
      end
    end
  end

  contador_saturado #(
    .ANCHO_CNT (ANCHO_CNT)
  ) u_contador (
    .clk    (clk),
    .rst    (rst),
    .borrar (borrar),
    .inc    (aceptar && v_entrada),
    .cuenta (cnt_overflow)
  );

  assign out_resultado = resultado_reg;
  assign out_banderas  = banderas_reg;
  assign out_valid     = valid_reg;
  assign v_pegajoso    = pegajoso_reg;

endmodule

// File: tb/tb_registro_banderas.sv
// Scoreboard bench for registro_banderas: the driver queues the expected output
// of every accepted entry and a monitor compares whenever an entry is given.
module tb_registro_banderas;

  localparam int ANCHO     = 4;
  localparam int ANCHO_CNT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ANCHO-1:0]     resultado;
  logic                 carry;
  logic                 overflow;
  logic [3:0]           seleccion;
  logic                 in_valid;
  logic                 in_ready;
  logic [ANCHO-1:0]     out_resultado;
  logic [3:0]           out_banderas;
  logic                 out_valid;
  logic                 out_ready;
  logic                 borrar;
  logic                 v_pegajoso;
  logic [ANCHO_CNT-1:0] cnt_overflow;

  typedef struct packed {
    logic [ANCHO-1:0]     res;
    logic [3:0]           fl;
    logic                 peg;
    logic [ANCHO_CNT-1:0] cnt;
  } esp_t;

  esp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   run       = 0;

  registro_banderas #(
    .ANCHO     (ANCHO),
    .ANCHO_CNT (ANCHO_CNT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .resultado     (resultado),
    .carry         (carry),
    .overflow      (overflow),
    .seleccion     (seleccion),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_resultado (out_resultado),
    .out_banderas  (out_banderas),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .borrar        (borrar),
    .v_pegajoso    (v_pegajoso),
    .cnt_overflow  (cnt_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nombre, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
      $display("check %s: got %0h ok", nombre, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
    end
  endtask

  // Monitor: every give pops the oldest expected entry.
  always @(negedge clk) begin
    esp_t e;
    if (out_valid) run++;
    else run = 0;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("give_without_expected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_entry", {out_resultado, out_banderas, v_pegajoso, cnt_overflow}, int'(e));
      end
    end
  end

  // Offer one entry, wait (bounded) for in_ready, queue its expected output.
  task automatic enviar(input logic [3:0] r, input logic c, input logic o,
                        input logic [3:0] sel, input logic b,
                        input logic [3:0] fl, input logic peg,
                        input logic [ANCHO_CNT-1:0] cn);
    int espera;
    resultado = r; carry = c; overflow = o; seleccion = sel; borrar = b;
    in_valid  = 1'b1;
    espera = 0;
    @(negedge clk);
    while (!in_ready && espera < 20) begin
      espera++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    sb.push_back({r, fl, peg, cn});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    borrar   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; resultado = '0; carry = 0; overflow = 0; seleccion = '0;
    in_valid = 0; out_ready = 1; borrar = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_resultado", int'(out_resultado), 0);
    chk("rst_out_banderas", int'(out_banderas), 0);
    chk("rst_v_pegajoso", int'(v_pegajoso), 0);
    chk("rst_cnt_overflow", int'(cnt_overflow), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Basic flag derivation (expected {N,Z,C,V}, sticky, count).
    enviar(4'h0, 1, 0, 4'b0000, 0, 4'b0110, 0, 0);
    enviar(4'h8, 0, 1, 4'b0000, 0, 4'b1001, 1, 1);
    enviar(4'h8, 0, 1, 4'b0100, 0, 4'b1000, 1, 1);
    enviar(4'h5, 1, 0, 4'b0001, 0, 4'b0010, 1, 1);
    enviar(4'hF, 1, 1, 4'b1000, 0, 4'b1000, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: entry 3 held while entry 6 waits.
    out_ready = 1'b0;
    enviar(4'h3, 0, 1, 4'b0000, 0, 4'b0001, 1, 2);
    resultado = 4'h6; carry = 1; overflow = 0; seleccion = 4'b0000; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_resultado", int'(out_resultado), 3);
      chk("stall_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    sb.push_back({4'h6, 4'b0010, 1'b1, 2'd2});
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Counter saturation, then clear together with an overflow accept.
    enviar(4'h1, 0, 1, 4'b0000, 0, 4'b0001, 1, 3);
    enviar(4'h2, 0, 1, 4'b0000, 0, 4'b0001, 1, 3);
    enviar(4'h4, 0, 1, 4'b0000, 0, 4'b0001, 1, 3);
    enviar(4'hA, 0, 1, 4'b0000, 0, 4'b1001, 1, 3);
    enviar(4'h0, 1, 1, 4'b0000, 0, 4'b0111, 1, 3);
    enviar(4'h7, 0, 1, 4'b0000, 1, 4'b0001, 0, 0);
    enviar(4'hC, 0, 1, 4'b0000, 0, 4'b1001, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    // Streaming eight entries back to back: no bubbles allowed.
    for (int k = 0; k < 8; k++) begin
      enviar(4'(k), 1, 1, 4'b1100, 0, (k == 0) ? 4'b0100 : 4'b0000, 1, 1);
    end
    @(negedge clk);
    #1;
    chk("stream_consecutive_valid", run, 8);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", sb.size(), 0);

    // Asynchronous reset while an entry is stalled on the output.
    out_ready = 1'b0;
    resultado = 4'h9; carry = 0; overflow = 1; seleccion = 4'b0000; in_valid = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_out_valid", int'(out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_resultado", int'(out_resultado), 0);
    chk("arst_out_banderas", int'(out_banderas), 0);
    chk("arst_v_pegajoso", int'(v_pegajoso), 0);
    chk("arst_cnt_overflow", int'(cnt_overflow), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("final_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/registro_banderas.md
# registro_banderas

Registered result-and-flags stage directly downstream of the ALU's combinational result, carry and overflow logic. It accepts one ALU result per valid/ready handshake and holds it in a single output register. It derives the N, Z, C and V flags and forwards them to the consumer, also under valid/ready. It additionally keeps a sticky overflow flag and a saturating count of overflow events for the status display.

## Interface
- Parameter `ANCHO`, default 4: result width in bits, ≥2.
- Parameter `ANCHO_CNT`, default 8: overflow event counter width.
- Port `clk`, input, 1: single clock; all state updates on its rising edge.
- Port `rst`, input, 1: reset, asynchronous and active-high.
- Port `resultado`, input, `ANCHO`: ALU result.
- Port `carry`, input, 1: ALU carry/borrow out.
- Port `overflow`, input, 1: ALU signed-overflow bit.
- Port `seleccion`, input, 4: ALU operation select accompanying the result.
- Port `in_valid`, input, 1: upstream result valid.
- Port `in_ready`, output, 1: stage can accept.
- Port `out_resultado`, output, `ANCHO`: registered result.
- Port `out_banderas`, output, 4: registered flags {N, Z, C, V}.
- Port `out_valid`, output, 1: output register holds data.
- Port `out_ready`, input, 1: downstream accepts.
- Port `borrar`, input, 1: synchronous clear of the sticky flag and the counter.
- Port `v_pegajoso`, output, 1: set by any accepted result with V=1.
- Port `cnt_overflow`, output, `ANCHO_CNT`: number of accepted results with V=1, saturating.

## Operation
- Accept condition: `in_valid && in_ready`. Give condition: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. The output register is one entry and is pass-through-ready.
- On accept:
  - `out_resultado <= resultado`.
  - N = `resultado[ANCHO-1]`.
  - Z = (`resultado` == 0).
  - C = `carry` only when `seleccion[3:2]==2'b00` (arithmetic class); otherwise 0.
  - V = `overflow` only when `seleccion[3:2]==2'b00`; otherwise 0.
  - `out_valid <= 1`.
- On give without accept: `out_valid <= 0`. Data and flags hold their last values.
- On give and accept in the same cycle: the new entry replaces the old one and `out_valid` stays 1. No bubble.
- While `out_valid` is 1 and `out_ready` is 0, the output values are stable and the input is stalled.
- Sticky flag and counter update only on an accepted entry with V=1:
  - `v_pegajoso <= 1`.
  - `cnt_overflow` increments, saturating at 2^`ANCHO_CNT`−1 (no wrap).
- `borrar` has priority over a simultaneous V=1 accept:
  - Both `v_pegajoso` and `cnt_overflow` are cleared to 0 in that cycle.
  - The accepted entry still loads normally into the output register.
- `borrar` does not affect the data path or the handshake.

## Timing
- Reset values, all outputs: `out_valid`=0, `out_resultado`=0, `out_banderas`=4'b0000, `v_pegajoso`=0, `cnt_overflow`=0, `in_ready`=1.
- Reset asserted mid-transfer discards the held entry immediately (asynchronous). The first accept is possible on the first rising edge after `rst` falls.
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`/`out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- `v_pegajoso` and `cnt_overflow` reflect an accepted V=1 entry in the same cycle that the entry appears on the output.

## Structure
- Package `alu_pkg`:
  - Packed struct `banderas_t` {n, z, c, v}.
  - Constant `CLASE_ARIT = 2'b00` for `seleccion[3:2]`.
  - Flag bit-index constants.
- Sub-module `contador_saturado`, parameter `ANCHO_CNT`:
  - Inputs `clk`, `rst`, `borrar`, `inc`; output `cuenta`.
  - Clear has priority over increment.
  - Instantiated once.
- Flag derivation is a function in `alu_pkg`, reused by other ALU stages.

## Test plan
- Reset, then `resultado`=4'h0, `seleccion`=4'b0000, `carry`=1, `overflow`=0, one accept → next cycle `out_valid`=1, `out_banderas`={0,1,1,0}.
- `resultado`=4'h8, `seleccion`=4'b0000, `overflow`=1, accepted → N=1, V=1, `v_pegajoso`=1, `cnt_overflow`=1. The same inputs with `seleccion`=4'b0100 → C=0, V=0, and the count stays unchanged.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, the output stays stable, and no accept occurs. Release `out_ready` → give and accept happen in the same cycle, `out_valid` stays 1, and the new entry appears on the output the following cycle.
- `ANCHO_CNT`=2, five V=1 accepts → `cnt_overflow` sticks at 3. Assert `borrar` together with a sixth V=1 accept → `cnt_overflow`=0, `v_pegajoso`=0, and that entry is still output with V=1.
- Assert `rst` while `out_valid`=1 and `out_ready`=0 → all outputs return to reset values immediately, before the next clock edge.
- Streaming 8 results with `out_ready`=1 → 8 consecutive output cycles, in order, with no bubbles.
